fifo_rv_prefetch: RTL and testbench
===================================

Name: fifo_rv_prefetch

Overview:
Downstream stage of the synchronous flushable FIFO. It drains the FIFO through its r_en/empty/r_data interface and presents a registered valid/ready stream to the consumer. A 2-entry prefetch (head + skid) sustains one transfer per cycle with no combinational path from out_ready_i to fifo_r_en_o. A shared flush clears the FIFO and this stage in the same cycle.

Parameters:
DATA_WIDTH, 32, width of a FIFO entry and of out_data_o

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
flush  input  1  synchronous clear; same signal drives the FIFO's flush
fifo_r_en_o  output  1  pop strobe to FIFO; data is consumed the same cycle
fifo_r_data_i  input  DATA_WIDTH  FIFO head data; combinationally valid while FIFO non-empty
fifo_empty_i  input  1  FIFO empty flag
out_valid_o  output  1  head entry valid
out_ready_i  input  1  consumer accepts head
out_data_o  output  DATA_WIDTH  head entry data, registered
count_o  output  2  occupancy of the stage (0..2)

Behaviour:
- State: head_q, skid_q (DATA_WIDTH each), cnt_q (2 bits, 0..2). Legal cnt_q values only; 3 never reached.
- Reset (async, rst_n=0): cnt_q=0, head_q=0, skid_q=0. Outputs: out_valid_o=0, out_data_o=0, count_o=0, fifo_r_en_o=0.
- fifo_r_en_o = !flush && !fifo_empty_i && (cnt_q != 2). Depends only on flush, empty and registered state; never on out_ready_i.
- pop = fifo_r_en_o; fire = out_valid_o && out_ready_i.
- out_valid_o = (cnt_q != 0); out_data_o = head_q; count_o = cnt_q.
- Transitions (flush=0):
  - cnt 0, pop: head<=in, cnt->1.
  - cnt 1, fire only: cnt->0, head holds stale value.
  - cnt 1, pop only: skid<=in, cnt->2.
  - cnt 1, fire+pop: head<=in, cnt stays 1.
  - cnt 2, fire: head<=skid, cnt->1. Pop is impossible at cnt 2.
  - No fire and no pop: all state holds.
- Latency: the FIFO's first word appears on out_valid_o/out_data_o 1 cycle after the pop cycle. Steady-state throughput is 1 word/cycle with out_ready_i held high. The skid entry absorbs the in-flight pop when the consumer stalls.
- Handshake: once out_valid_o=1, out_data_o is stable until fire or flush. A valid is never withdrawn except by flush or reset.
- Flush (highest priority after reset):
  - cnt_q<=0, head_q<=0, skid_q<=0.
  - fifo_r_en_o forced 0 in the flush cycle.
  - A consumer fire in the flush cycle is ignored; the data is discarded, and the consumer must tolerate this.
  - Next cycle: out_valid_o=0, out_data_o=0.
- Empty FIFO: no pop. The stage drains its contents normally.
- Reset mid-transfer: all state clears immediately and asynchronously. The FIFO resets on the same rst_n.
- Ordering: strict FIFO order is preserved. The skid entry is always younger than head.

Test Plan:
- Reset: rst_n=0 with FIFO holding 3 words -> out_valid_o=0, out_data_o=0, count_o=0, fifo_r_en_o=0. After release, first pop next cycle; out_data_o=word0 one cycle later.
- Streaming: FIFO preloaded 0x11,0x22,0x33,0x44; out_ready_i=1 throughout -> out_valid_o high 4 consecutive cycles with data 0x11..0x44 in order; count_o stays 1; then out_valid_o=0, count_o=0.
- Backpressure: preload 0xA0,0xA1,0xA2; out_ready_i=0 -> exactly 2 pops, count_o=2, fifo_r_en_o=0 thereafter, out_data_o=0xA0 held. Raise out_ready_i -> outputs 0xA0,0xA1,0xA2 back-to-back, nothing lost or duplicated.
- Flush: count_o=2 (0x5,0x6 held), assert flush 1 cycle with out_ready_i=1 -> fifo_r_en_o=0 that cycle; next cycle out_valid_o=0, out_data_o=0, count_o=0. A new FIFO write of 0x7 then appears as the next output.
- Trickle/empty toggling: FIFO written every 3rd cycle with 1,2,3, out_ready_i=1 -> each word output exactly once, 1 cycle after its pop; out_valid_o low between words; no pop while fifo_empty_i=1.
- Random ready: 200 random words with random out_ready_i -> scoreboard order match; fifo_r_en_o never high when count_o=2 or fifo_empty_i=1.

Source files
------------

// File: rtl/fifo_rv_prefetch.sv
// Drains a synchronous FIFO into a registered valid/ready stream through a
// two-entry prefetch (head + skid); a shared flush clears FIFO and stage together.
module fifo_rv_prefetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  fifo_r_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_i,
  input  logic                  fifo_empty_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [1:0]            r_cnt;
  logic                  w_pop;
  logic                  w_fire;

  // The pop strobe is built only from flush, empty and registered occupancy, so
  // the consumer's ready never reaches the FIFO combinationally; rst_n keeps the
  // strobe quiet while the stage is held in reset.
  assign w_pop  = rst_n && !flush && !fifo_empty_i && (r_cnt != 2'd2);
  assign w_fire = out_valid_o && out_ready_i;

  assign fifo_r_en_o = w_pop;
  assign out_valid_o = (r_cnt != 2'd0);
  assign out_data_o  = r_head;
  assign count_o     = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_pop) begin
            r_head <= fifo_r_data_i;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_fire && w_pop) begin
            r_head <= fifo_r_data_i;
          end else if (w_fire) begin
            r_cnt <= 2'd0;
          end else if (w_pop) begin
            r_skid <= fifo_r_data_i;
            r_cnt  <= 2'd2;
          end
        end
        2'd2: begin
          // Skid is always the younger entry, so it moves up into head on a fire.
          if (w_fire) begin
            r_head <= r_skid;
            r_cnt  <= 2'd1;
          end
        end
        default: begin
          r_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rv_prefetch.sv
// Randomised scoreboard bench for fifo_rv_prefetch: a queue-based FIFO feeds the
// stage, written words are queued as expected output, and a monitor checks every cycle.
module tb_fifo_rv_prefetch;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_r_en_o;
  logic [DW-1:0] fifo_r_data_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [1:0]    count_o;

  logic          wrEn = 1'b0;
  logic [DW-1:0] wrData = '0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] expQ[$];
  bit            sPop = 1'b0;
  bit            sFlush = 1'b0;
  bit            sWr = 1'b0;
  logic [DW-1:0] sWrData = '0;

  int            checks = 0;
  int            errors = 0;
  int            modelCount = 0;
  logic [DW-1:0] idleData = '0;
  bit            monExpPop;
  bit            monFire;

  fifo_rv_prefetch #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_r_en_o  (fifo_r_en_o),
    .fifo_r_data_i(fifo_r_data_i),
    .fifo_empty_i (fifo_empty_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, changed just after the rising edge.
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] d, input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    wrEn        = wr;
    wrData      = d;
    out_ready_i = rdy;
    flush       = fl;
    if (wr) expQ.push_back(d);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic drainAll();
    for (int i = 0; i < 400 && expQ.size() != 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    checkOutput("drainEmpty", DW'(expQ.size()), '0);
  endtask

  // Behavioural FIFO: inputs sampled mid-cycle, contents updated on the edge.
  always @(negedge clk) begin
    sPop    = fifo_r_en_o;
    sFlush  = flush;
    sWr     = wrEn;
    sWrData = wrData;
  end

  always @(posedge clk) begin
    if (sFlush) begin
      fifoQ.delete();
    end else begin
      if (sPop && fifoQ.size() != 0) fifoQ.delete(0);
      if (sWr) fifoQ.push_back(sWrData);
    end
    fifo_empty_i  <= (fifoQ.size() == 0);
    fifo_r_data_i <= (fifoQ.size() != 0) ? fifoQ[0] : '0;
  end

  // Monitor: the stage holds the oldest modelCount words of expQ, head first.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int i = 0; i < modelCount; i++) if (expQ.size() != 0) expQ.delete(0);
      modelCount = 0;
      idleData   = '0;
      checkOutput("rstValid", DW'(out_valid_o), '0);
      checkOutput("rstData", out_data_o, '0);
      checkOutput("rstCount", DW'(count_o), '0);
      checkOutput("rstPop", DW'(fifo_r_en_o), '0);
    end else begin
      monExpPop = !flush && !fifo_empty_i && (modelCount != 2);
      monFire   = (modelCount != 0) && out_ready_i;
      checkOutput("popStrobe", DW'(fifo_r_en_o), DW'(monExpPop));
      checkOutput("valid", DW'(out_valid_o), DW'(modelCount != 0));
      checkOutput("count", DW'(count_o), DW'(modelCount));
      if (modelCount != 0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboardUnderflow actual=0x%0h required=<queued word>", out_data_o);
        end else begin
          checkOutput("headData", out_data_o, expQ[0]);
        end
      end else begin
        checkOutput("idleData", out_data_o, idleData);
      end
      if (flush) begin
        expQ.delete();
        modelCount = 0;
        idleData   = '0;
      end else begin
        if (monFire && expQ.size() != 0) begin
          idleData = expQ[0];
          expQ.delete(0);
        end
        modelCount = modelCount + int'(monExpPop) - int'(monFire);
      end
    end
  end

  initial begin
    int sent;
    bit wr;
    bit rdy;
    bit fl;

    // Reset held while the FIFO already has three words waiting.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h101, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h102, 1'b0, 1'b0);
    idle(2, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2, 1'b0);
    drainAll();

    // Streaming with the consumer always ready.
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Backpressure: stage fills to two, then releases in order.
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(5, 1'b1);

    // Flush with a full stage and a ready consumer.
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h7, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Trickle: one word every third cycle.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
      idle(2, 1'b1);
    end
    idle(2, 1'b1);

    // Asynchronous reset while the stage is full and the FIFO holds one more word.
    applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
    idle(3, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle(2, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drainAll();

    // Random traffic with random ready and occasional flushes.
    sent = 0;
    while (sent < 200) begin
      wr  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = !wr && ($urandom_range(0, 49) == 0);
      applyStimulus(wr, $urandom, rdy, fl);
      if (wr) sent++;
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    drainAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
